// File: rtl/muldiv_if.sv
// Pipeline and multiply/divide resource signals of the EX-stage mul/div sequencer.
// The slave side is the sequencer; the master side is the pipeline plus the arithmetic units.
interface muldiv_if;
  logic        flush;
  logic        stall_in;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        muldiv_stall;
  logic        result_valid;
  logic [63:0] result;
  logic        mul_start;
  logic        mul_sign;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_cancel;
  logic        div_done;
  logic [63:0] div_result;

  modport master (
    output flush, stall_in, op_valid, op_type, src_a, src_b,
    output mul_result, div_done, div_result,
    input  muldiv_stall, result_valid, result,
    input  mul_start, mul_sign, mul_a, mul_b,
    input  div_start, div_sign, div_a, div_b, div_cancel
  );

  modport slave (
    input  flush, stall_in, op_valid, op_type, src_a, src_b,
    input  mul_result, div_done, div_result,
    output muldiv_stall, result_valid, result,
    output mul_start, mul_sign, mul_a, mul_b,
    output div_start, div_sign, div_a, div_b, div_cancel
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer: launches one mult/multu/div/divu, stalls the pipeline until the
// 64-bit {hi,lo} result is ready, and holds it until the pipeline releases it.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        mul_start_q, mul_start_d;
  logic        mul_sign_q, mul_sign_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        div_start_q, div_start_d;
  logic        div_sign_q, div_sign_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        div_cancel_q, div_cancel_d;
  logic        accept;

  assign accept = (state_q == IDLE) & bus.op_valid & ~bus.flush;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    mul_start_d    = 1'b0;
    mul_sign_d     = mul_sign_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    div_start_d    = 1'b0;
    div_sign_d     = div_sign_q;
    div_a_d        = div_a_q;
    div_b_d        = div_b_q;
    div_cancel_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.op_type[1]) begin
            mul_a_d     = bus.src_a;
            mul_b_d     = bus.src_b;
            mul_sign_d  = ~bus.op_type[0];
            mul_start_d = 1'b1;
            cnt_d       = 4'(MUL_LAT);
            state_d     = MUL_WAIT;
          end else if (bus.src_b == 32'd0) begin
            // Divide by zero never reaches the divider; the result is defined as zero.
            result_d = '0;
            state_d  = DONE;
          end else begin
            div_a_d     = bus.src_a;
            div_b_d     = bus.src_b;
            div_sign_d  = ~bus.op_type[0];
            div_start_d = 1'b1;
            state_d     = DIV_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          result_d = bus.mul_result;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DIV_WAIT: begin
        // A done strobe coinciding with our own start pulse belongs to no operation of ours.
        if (bus.flush) begin
          div_cancel_d = 1'b1;
          state_d      = IDLE;
        end else if (bus.div_done && !div_start_q) begin
          result_d = bus.div_result;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.flush || !bus.stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    result_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      mul_start_q    <= 1'b0;
      mul_sign_q     <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      div_start_q    <= 1'b0;
      div_sign_q     <= 1'b0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      div_cancel_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      mul_start_q    <= mul_start_d;
      mul_sign_q     <= mul_sign_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      div_start_q    <= div_start_d;
      div_sign_q     <= div_sign_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      div_cancel_q   <= div_cancel_d;
    end
  end

  // Stall is combinational in IDLE so the accept cycle itself is held.
  assign bus.muldiv_stall = ~rst & ((state_q == MUL_WAIT) | (state_q == DIV_WAIT) | accept);
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_sign     = mul_sign_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.div_start    = div_start_q;
  assign bus.div_sign     = div_sign_q;
  assign bus.div_a        = div_a_q;
  assign bus.div_b        = div_b_q;
  assign bus.div_cancel   = div_cancel_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural multiplier/divider models, a vector table with a
// result scoreboard, and directed flush, stall-hold and reset sequences.
module tb_muldiv_ctrl;

  localparam int unsigned MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if bus();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;
  int div_lat = 4;
  int exp_mul_st = 0;
  int exp_div_st = 0;
  int n_mul_start = 0;
  int n_div_start = 0;
  int n_cancel = 0;

  function automatic logic [63:0] mul_ref(logic s, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] div_ref(logic s, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sbv;
    logic [31:0] q, r;
    sa = a;
    sbv = b;
    if (s) begin
      q = sa / sbv;
      r = sa % sbv;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Multiplier model: product valid only in the cycle MUL_LAT after the start cycle.
  logic        m_act = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_prod = '0;
  always @(posedge clk) begin
    if (rst) m_act <= 1'b0;
    else if (bus.mul_start) begin
      m_act  <= 1'b1;
      m_cnt  <= int'(MUL_LAT) - 1;
      m_prod <= mul_ref(bus.mul_sign, bus.mul_a, bus.mul_b);
    end else if (m_act) begin
      if (m_cnt == 0) m_act <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end
  end
  assign bus.mul_result = (m_act && m_cnt == 0) ? m_prod : 64'hDEAD_BEEF_DEAD_BEEF;

  // Divider model: done div_lat cycles after start; also strobes garbage in the start cycle.
  logic        d_act = 1'b0;
  int          d_cnt = 0;
  logic [63:0] d_res = '0;
  always @(posedge clk) begin
    if (rst || bus.div_cancel) d_act <= 1'b0;
    else if (bus.div_start) begin
      d_act <= 1'b1;
      d_cnt <= div_lat;
      d_res <= div_ref(bus.div_sign, bus.div_a, bus.div_b);
    end else if (d_act) begin
      if (d_cnt == 1) d_act <= 1'b0;
      else d_cnt <= d_cnt - 1;
    end
  end
  assign bus.div_done   = bus.div_start | (d_act && d_cnt == 1);
  assign bus.div_result = (d_act && d_cnt == 1) ? d_res : 64'hBAD0_BAD0_BAD0_BAD0;

  always @(posedge clk) begin
    if (bus.mul_start)  n_mul_start <= n_mul_start + 1;
    if (bus.div_start)  n_div_start <= n_div_start + 1;
    if (bus.div_cancel) n_cancel    <= n_cancel + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input string nm);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: result %h produced with empty scoreboard", nm, bus.result);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_res"}, bus.result, e);
    end
  endtask

  task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                        input int dl, input logic [63:0] exp, input int exp_lat, input string nm);
    int lat;
    logic s;
    s = ~t[0];
    sb_q.push_back(exp);
    div_lat = dl;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_type = t; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    chk({nm, "_stall_acc"}, 64'(bus.muldiv_stall), 64'd1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    if (!t[1]) begin
      exp_mul_st++;
      chk({nm, "_mstart"}, 64'(bus.mul_start), 64'd1);
      chk({nm, "_msign"}, 64'(bus.mul_sign), 64'(s));
      chk({nm, "_mops"}, {bus.mul_a, bus.mul_b}, {a, b});
    end else if (b != 32'd0) begin
      exp_div_st++;
      chk({nm, "_dstart"}, 64'(bus.div_start), 64'd1);
      chk({nm, "_dsign"}, 64'(bus.div_sign), 64'(s));
      chk({nm, "_dops"}, {bus.div_a, bus.div_b}, {a, b});
    end else begin
      chk({nm, "_dz_nostart"}, 64'(bus.div_start), 64'd0);
    end
    lat = 1;
    while (!bus.result_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    if (bus.result_valid) sb_pop(nm);
    chk({nm, "_stall_done"}, 64'(bus.muldiv_stall), 64'd0);
    last_res = exp;
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    int          dl;
    logic [63:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int s0;
    int bad;
    logic [63:0] r0;

    bus.flush = 1'b0; bus.stall_in = 1'b0; bus.op_valid = 1'b1;
    bus.op_type = 2'b00; bus.src_a = 32'd1; bus.src_b = 32'd1;
    rst = 1'b1;
    last_res = '0;

    // Reset held two cycles with op_valid asserted
    @(posedge clk);
    @(negedge clk);
    chk("rst_rv", 64'(bus.result_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_ctrl", {59'd0, bus.mul_start, bus.div_start, bus.div_cancel, bus.mul_sign, bus.div_sign}, 64'd0);
    chk("rst_stall", 64'(bus.muldiv_stall), 64'd0);
    chk("rst_mops", {bus.mul_a, bus.mul_b}, 64'd0);
    chk("rst_dops", {bus.div_a, bus.div_b}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.op_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 64'(bus.muldiv_stall), 64'd0);
    chk("post_rst_nostart", {62'd0, bus.mul_start, bus.div_start}, 64'd0);

    vecs.push_back('{2'b00, 32'hFFFF_FFFE, 32'd3,          1,  64'hFFFF_FFFF_FFFF_FFFA, 4,  "mult_m2x3"});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd2,          1,  64'h0000_0001_FFFF_FFFE, 4,  "multu_max2"});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  1,  64'hFFFF_FFFE_0000_0001, 4,  "multu_maxmax"});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000,  1,  64'h4000_0000_0000_0000, 4,  "mult_minmin"});
    vecs.push_back('{2'b11, 32'd100,       32'd7,          33, 64'h0000_0002_0000_000E, 35, "divu_100_7"});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,          5,  64'hFFFF_FFFF_FFFF_FFFD, 7,  "div_m7_2"});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,          1,  64'h0000_0001_7FFF_FFFC, 3,  "divu_big_2"});
    vecs.push_back('{2'b10, 32'd100,       32'hFFFF_FFF9,  10, 64'h0000_0002_FFFF_FFF2, 12, "div_100_m7"});
    vecs.push_back('{2'b10, 32'd5,         32'd0,          1,  64'd0,                   1,  "div_by0"});
    vecs.push_back('{2'b11, 32'h0000_1234, 32'd0,          1,  64'd0,                   1,  "divu_by0"});

    foreach (vecs[i]) run_op(vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].dl, vecs[i].exp, vecs[i].lat, vecs[i].nm);

    // Flush coinciding with div_done
    div_lat = 6;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_type = 2'b10; bus.src_a = 32'd50; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    exp_div_st++;
    repeat (6) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_done_coincide", 64'(bus.div_done), 64'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("fl_cancel", 64'(bus.div_cancel), 64'd1);
    chk("fl_rv", 64'(bus.result_valid), 64'd0);
    chk("fl_nocapture", bus.result, last_res);
    chk("fl_idle_stall", 64'(bus.muldiv_stall), 64'd0);
    @(negedge clk);
    chk("fl_cancel_1cyc", 64'(bus.div_cancel), 64'd0);
    chk("fl_rv2", 64'(bus.result_valid), 64'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1, 64'h0000_0001_FFFF_FFFE, 4, "multu_after_fl");

    // Flush while the multiplier is busy
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_type = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    exp_mul_st++;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.result_valid || bus.muldiv_stall) bad++;
    end
    chk("mfl_quiet", 64'(bad), 64'd0);
    chk("mfl_nocapture", bus.result, last_res);
    chk("mfl_nocancel", 64'(n_cancel), 64'd1);

    // Flush in the accept cycle
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.flush = 1'b1; bus.op_type = 2'b10; bus.src_a = 32'd9; bus.src_b = 32'd3;
    @(negedge clk);
    chk("afl_stall", 64'(bus.muldiv_stall), 64'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("afl_nostart", {62'd0, bus.mul_start, bus.div_start}, 64'd0);

    // Result held under stall_in, op_valid left high, then a new op right after release
    bus.stall_in = 1'b1;
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFF9);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_type = 2'b00; bus.src_a = 32'd7; bus.src_b = 32'hFFFF_FFFF;
    exp_mul_st++;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.result_valid && lat < 300);
    chk("hold_lat", 64'(lat), 64'd5);
    if (bus.result_valid) sb_pop("hold_first");
    r0 = bus.result;
    s0 = n_mul_start;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk("hold_rv", 64'(bus.result_valid), 64'd1);
      chk("hold_res", bus.result, r0);
    end
    @(posedge clk); #1;
    bus.stall_in = 1'b0; bus.op_type = 2'b01; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'd2;
    sb_q.push_back(64'h0000_0001_FFFF_FFFE);
    @(negedge clk);
    chk("hold_rv_last", 64'(bus.result_valid), 64'd1);
    chk("hold_res_last", bus.result, r0);
    @(negedge clk);
    chk("rel_rv", 64'(bus.result_valid), 64'd0);
    chk("rel_accept_stall", 64'(bus.muldiv_stall), 64'd1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk("rel_mstart", 64'(bus.mul_start), 64'd1);
    chk("hold_no_relaunch", 64'(n_mul_start), 64'(s0));
    exp_mul_st++;
    lat = 1;
    while (!bus.result_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("rel_lat", 64'(lat), 64'd4);
    if (bus.result_valid) sb_pop("rel_op");
    last_res = 64'h0000_0001_FFFF_FFFE;

    // Reset in the middle of a divide
    div_lat = 20;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_type = 2'b11; bus.src_a = 32'd77; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    exp_div_st++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rv", 64'(bus.result_valid), 64'd0);
    chk("mrst_result", bus.result, 64'd0);
    chk("mrst_dops", {bus.div_a, bus.div_b}, 64'd0);
    chk("mrst_ctrl", {60'd0, bus.div_cancel, bus.div_sign, bus.muldiv_stall, bus.div_start}, 64'd0);
    @(negedge clk);
    chk("mrst_nocancel", 64'(bus.div_cancel), 64'd0);
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1, 64'hFFFF_FFFF_FFFF_FFFA, 4, "mult_after_rst");

    @(negedge clk);
    chk("cnt_mul_start", 64'(n_mul_start), 64'(exp_mul_st));
    chk("cnt_div_start", 64'(n_div_start), 64'(exp_div_st));
    chk("cnt_cancel", 64'(n_cancel), 64'd1);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
